// File: rtl/alu_exec_if.sv
// alu_exec_if: operand, decode and flag bundle between the ALU execute unit and its driver
interface alu_exec_if #(parameter int WIDTH = 32);
  logic             aluop1;
  logic             aluop0;
  logic [3:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       gout;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  modport master (
    output aluop1, aluop0, funct, a, b, add_a, add_b,
    input  gout, result, zero, neg, ovf, zero_q, neg_q, ovf_q, add_sum
  );
  modport slave (
    input  aluop1, aluop0, funct, a, b, add_a, add_b,
    output gout, result, zero, neg, ovf, zero_q, neg_q, ovf_q, add_sum
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU control decode, combinational ALU with flags, registered flags and a free adder
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  bus
);
  logic [1:0]       aluop;
  logic [2:0]       rtype;
  logic [2:0]       g;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] r;
  logic             lt;
  logic             ovf;
  always_comb begin
    aluop = {bus.aluop1, bus.aluop0};
    rtype = bus.funct == 4'b0010 ? 3'b110 :
            bus.funct == 4'b0100 ? 3'b000 :
            bus.funct == 4'b0101 ? 3'b001 :
            bus.funct == 4'b0111 ? 3'b100 :
            bus.funct == 4'b1010 ? 3'b111 : 3'b010;
    g     = aluop == 2'b00 ? 3'b010 :
            aluop == 2'b01 ? 3'b110 :
            aluop == 2'b11 ? 3'b001 : rtype;
    sum   = bus.a + bus.b;
    diff  = bus.a - bus.b;
    // signed compare directly rather than from diff's sign, so SLT stays exact on overflow
    lt    = $signed(bus.a) < $signed(bus.b);
    r     = g == 3'b010 ? sum :
            g == 3'b110 ? diff :
            g == 3'b000 ? bus.a & bus.b :
            g == 3'b001 ? bus.a | bus.b :
            g == 3'b100 ? ~(bus.a | bus.b) :
            g == 3'b111 ? {{(WIDTH-1){1'b0}}, lt} : '0;
    ovf   = g == 3'b010 ? (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (r[WIDTH-1] != bus.a[WIDTH-1]) :
            g == 3'b110 ? (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (r[WIDTH-1] != bus.a[WIDTH-1]) : 1'b0;
  end
  assign bus.gout    = g;
  assign bus.result  = r;
  assign bus.zero    = r == '0;
  assign bus.neg     = r[WIDTH-1];
  assign bus.ovf     = ovf;
  assign bus.add_sum = bus.add_a + bus.add_b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.zero_q <= 1'b0;
      bus.neg_q  <= 1'b0;
      bus.ovf_q  <= 1'b0;
    end else begin
      bus.zero_q <= r == '0;
      bus.neg_q  <= r[WIDTH-1];
      bus.ovf_q  <= ovf;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with hand-computed expectations for alu_exec_unit
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  alu_exec_if #(.WIDTH(32)) bus ();
  alu_exec_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic [1:0] op, input logic [3:0] fn, input logic [31:0] av, input logic [31:0] bv);
    bus.aluop1 = op[1];
    bus.aluop0 = op[0];
    bus.funct  = fn;
    bus.a      = av;
    bus.b      = bv;
  endtask
  task automatic alu(input string tag, input logic [2:0] g, input logic [31:0] r,
                     input logic z, input logic n, input logic o);
    #1;
    chk({tag, ".gout"}, 32'(bus.gout), 32'(g));
    chk({tag, ".result"}, bus.result, r);
    chk({tag, ".zero"}, 32'(bus.zero), 32'(z));
    chk({tag, ".neg"}, 32'(bus.neg), 32'(n));
    chk({tag, ".ovf"}, 32'(bus.ovf), 32'(o));
  endtask
  task automatic flags(input string tag, input logic z, input logic n, input logic o);
    chk({tag, ".zero_q"}, 32'(bus.zero_q), 32'(z));
    chk({tag, ".neg_q"}, 32'(bus.neg_q), 32'(n));
    chk({tag, ".ovf_q"}, 32'(bus.ovf_q), 32'(o));
  endtask
  initial begin
    bus.add_a = 32'h0;
    bus.add_b = 32'h0;
    drv(2'b10, 4'b0000, 32'h7FFFFFFF, 32'h00000001);
    #1 rst_n = 1'b0;
    #1 flags("reset", 1'b0, 1'b0, 1'b0);
    alu("rst_comb", 3'b010, 32'h80000000, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1 flags("reset_edges", 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    alu("add_ovf", 3'b010, 32'h80000000, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1 flags("add_ovf_q", 1'b0, 1'b1, 1'b1);
    drv(2'b01, 4'b0000, 32'h00000005, 32'h00000005);
    alu("sub_zero", 3'b110, 32'h00000000, 1'b1, 1'b0, 1'b0);
    flags("hold", 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1 flags("sub_zero_q", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drv(2'b01, 4'b0000, 32'h80000000, 32'h00000001);
    alu("sub_ovf_pos", 3'b110, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
    drv(2'b01, 4'b0000, 32'h7FFFFFFF, 32'hFFFFFFFF);
    alu("sub_ovf_neg", 3'b110, 32'h80000000, 1'b0, 1'b1, 1'b1);
    drv(2'b10, 4'b0010, 32'h00000003, 32'h00000005);
    alu("rsub", 3'b110, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0);
    drv(2'b00, 4'b0111, 32'hFFFFFFFF, 32'h00000001);
    alu("add_carry", 3'b010, 32'h00000000, 1'b1, 1'b0, 1'b0);
    drv(2'b10, 4'b1010, 32'h80000000, 32'h7FFFFFFF);
    alu("slt_true", 3'b111, 32'h00000001, 1'b0, 1'b0, 1'b0);
    drv(2'b10, 4'b1010, 32'h7FFFFFFF, 32'h80000000);
    alu("slt_false", 3'b111, 32'h00000000, 1'b1, 1'b0, 1'b0);
    drv(2'b10, 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00);
    alu("and", 3'b000, 32'hF000F000, 1'b0, 1'b1, 1'b0);
    drv(2'b10, 4'b0101, 32'hF0F0F0F0, 32'hFF00FF00);
    alu("or", 3'b001, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0);
    drv(2'b10, 4'b0111, 32'hF0F0F0F0, 32'hFF00FF00);
    alu("nor", 3'b100, 32'h000F000F, 1'b0, 1'b0, 1'b0);
    drv(2'b11, 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00);
    alu("op_or", 3'b001, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0);
    drv(2'b10, 4'b1111, 32'h00000010, 32'h00000020);
    alu("funct_dflt", 3'b010, 32'h00000030, 1'b0, 1'b0, 1'b0);
    bus.add_a = 32'hFFFFFFFC;
    bus.add_b = 32'h00000004;
    drv(2'b10, 4'b0100, 32'h0000FFFF, 32'h00FF00FF);
    alu("indep_and", 3'b000, 32'h000000FF, 1'b0, 1'b0, 1'b0);
    chk("add_sum_wrap", bus.add_sum, 32'h00000000);
    bus.add_a = 32'h12345678;
    bus.add_b = 32'h11111111;
    #1 chk("add_sum", bus.add_sum, 32'h23456789);
    chk("add_indep_res", bus.result, 32'h000000FF);
    drv(2'b00, 4'b0000, 32'h80000000, 32'h80000000);
    alu("add_zero_ovf", 3'b010, 32'h00000000, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1 flags("zo_q", 1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 flags("async_rst1", 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    drv(2'b00, 4'b0000, 32'h7FFFFFFF, 32'h00000001);
    @(posedge clk);
    #1 flags("no_q", 1'b0, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 flags("async_rst2", 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 flags("post_rst", 1'b0, 1'b1, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
